uart_tx_scheduler: RTL and testbench

Round-robin scheduler sharing one async UART transmitter among NREQ byte requesters. Each requester presents a byte with a request line. The scheduler grants one requester, latches its byte and issues a single start pulse to the transmitter. It tracks transmitter busy until the frame completes, inserts an optional inter-byte guard gap, then rotates priority. Sits between protocol producers (debug console, status reporter, echo path) and the single TxD pin driver.

---
 rtl/uart_sched_pkg.sv | 26 ++
 rtl/uart_tx_scheduler_rr_pick.sv | 41 ++++
 rtl/uart_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding,
// default timing constants and a constant-safe clog2 helper.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } sched_state_t;

    localparam int DEF_START_TIMEOUT = 16;
    localparam int DEF_GUARD_CYCLES  = 0;

    // Never returns less than 1 so a 1-entry index still has a bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr,
// wrapping modulo N. Reusable by any shared-resource arbiter.
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          valid
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest hit is kept.
    always_comb begin
        onehot = '0;
        idx    = '0;
        sum    = '0;
        cand   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            cand = sum[PW-1:0];
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// Optional packet lock (grant held until last byte) under `UART_TX_LOCK_EN.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              TxD_start,
    output logic [7:0]        TxD_data,
    input  logic              TxD_busy,
`ifdef UART_TX_LOCK_EN
    input  logic [NREQ-1:0]   last,
`endif
    output logic              err,
    output logic              active
);

    localparam int PW    = clog2(NREQ);
    localparam int CMAX  = (START_TIMEOUT > GUARD_CYCLES) ? START_TIMEOUT : GUARD_CYCLES;
    localparam int CW    = clog2(CMAX + 1);

    sched_state_t      state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [PW-1:0]     sel_reg, sel_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [NREQ-1:0]   ack_reg, ack_next;
    logic [NREQ-1:0]   grant_reg, grant_next;
    logic              start_reg, start_next;
    logic [7:0]        data_reg, data_next;
    logic              err_reg, err_next;
    logic              lock_reg, lock_next;

    logic [NREQ-1:0]   eff_req;
    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic [PW-1:0]     sel_inc;

`ifdef UART_TX_LOCK_EN
    logic [NREQ-1:0]   lock_mask;

    // While a packet is locked only its owner may be picked.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lock_mask
        assign lock_mask[gi] = (sel_reg == PW'(gi));
    end

    assign eff_req = lock_reg ? (req & lock_mask) : req;
`else
    assign eff_req = req;
`endif

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_pick (
        .req    (eff_req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign sel_inc = (sel_reg == PW'(NREQ - 1)) ? '0 : sel_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        ack_next   = '0;
        grant_next = grant_reg;
        start_next = 1'b0;
        data_next  = data_reg;
        err_next   = 1'b0;
        lock_next  = lock_reg;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    sel_next   = pick_idx;
                    ack_next   = pick_onehot;
                    grant_next = pick_onehot;
                    data_next  = data[{pick_idx, 3'b000} +: 8];
`ifdef UART_TX_LOCK_EN
                    lock_next  = !last[pick_idx];
`endif
                    state_next = START;
                end
            end
            START: begin
                start_next = 1'b1;
                cnt_next   = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TxD_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_reg == CW'(START_TIMEOUT)) begin
                    // Transmitter never acknowledged: drop the byte and any lock.
                    err_next   = 1'b1;
                    grant_next = '0;
                    ptr_next   = sel_inc;
                    lock_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!TxD_busy) begin
                    grant_next = '0;
                    cnt_next   = '0;
                    if (!lock_reg) begin
                        ptr_next = sel_inc;
                    end
                    state_next = (GUARD_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (cnt_reg == CW'(GUARD_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!RST) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            sel_reg   <= '0;
            cnt_reg   <= '0;
            ack_reg   <= '0;
            grant_reg <= '0;
            start_reg <= 1'b0;
            data_reg  <= 8'h00;
            err_reg   <= 1'b0;
            lock_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            grant_reg <= grant_next;
            start_reg <= start_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
            lock_reg  <= lock_next;
        end
    end

    assign ack       = ack_reg;
    assign grant     = grant_reg;
    assign TxD_start = start_reg;
    assign TxD_data  = data_reg;
    assign err       = err_reg;
    assign active    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (default and guard-gap
// instances; packet-lock steps compile in with UART_TX_LOCK_EN).
module tb_uart_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int FRAME = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_g;
    logic [31:0] data;
    logic        busy    = 1'b0;
    logic        busy_g  = 1'b0;
    logic        busy_en = 1'b1;
    int          frame_cnt   = 0;
    int          frame_cnt_g = 0;

    logic [3:0]  ack, grant, ack_g, grant_g;
    logic        start, start_g, err, err_g, active, active_g;
    logic [7:0]  txd, txd_g;

`ifdef UART_TX_LOCK_EN
    logic [3:0]  last;
    logic [3:0]  last_g;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(.NREQ(NREQ), .GUARD_CYCLES(0), .START_TIMEOUT(16)) dut (
        .CLK50MHZ  (clk),
        .RST       (rst_n),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .grant     (grant),
        .TxD_start (start),
        .TxD_data  (txd),
        .TxD_busy  (busy),
`ifdef UART_TX_LOCK_EN
        .last      (last),
`endif
        .err       (err),
        .active    (active)
    );

    uart_tx_scheduler #(.NREQ(NREQ), .GUARD_CYCLES(5), .START_TIMEOUT(16)) dut_g (
        .CLK50MHZ  (clk),
        .RST       (rst_n),
        .req       (req_g),
        .data      (data),
        .ack       (ack_g),
        .grant     (grant_g),
        .TxD_start (start_g),
        .TxD_data  (txd_g),
        .TxD_busy  (busy_g),
`ifdef UART_TX_LOCK_EN
        .last      (last_g),
`endif
        .err       (err_g),
        .active    (active_g)
    );

    // Transmitter models: busy rises just after a sampled start, lasts FRAME cycles.
    always @(posedge clk) begin
        #1;
        if (busy_en && start) frame_cnt = FRAME;
        else if (frame_cnt > 0) frame_cnt = frame_cnt - 1;
        busy = (frame_cnt > 0);
    end

    always @(posedge clk) begin
        #1;
        if (start_g) frame_cnt_g = FRAME;
        else if (frame_cnt_g > 0) frame_cnt_g = frame_cnt_g - 1;
        busy_g = (frame_cnt_g > 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0000 && n < 60);
        chk({tag, "_seen"}, 32'(ack != 4'b0000), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (active && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(active), 32'd0);
    endtask

    logic [7:0] bytes [4];
    int n, gapc, exp_i;
    logic [3:0] ack_or;

    initial begin
        bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'hA5; bytes[3] = 8'h3C;
        data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
        rst_n = 1'b0;
        req   = 4'b1111;
        req_g = 4'b0000;
`ifdef UART_TX_LOCK_EN
        last   = 4'b0000;
        last_g = 4'b0000;
`endif

        // Reset held with every request asserted.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ack", 32'(ack), 32'h0);
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_start", 32'(start), 32'h0);
            chk("rst_txd", 32'(txd), 32'h0);
            chk("rst_err", 32'(err), 32'h0);
            chk("rst_active", 32'(active), 32'h0);
        end
        rst_n = 1'b1;

        // Fairness: all requests held, expect 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            exp_i = k % 4;
            wait_ack($sformatf("fair%0d", k));
            chk($sformatf("fair%0d_ack", k), 32'(ack), 32'(4'b0001 << exp_i));
            chk($sformatf("fair%0d_grant", k), 32'(grant), 32'(4'b0001 << exp_i));
            chk($sformatf("fair%0d_data", k), 32'(txd), 32'(bytes[exp_i]));
            if (k == 4) req = 4'b0000;
            @(negedge clk);
            chk($sformatf("fair%0d_start", k), 32'(start), 32'd1);
        end
        wait_idle("fair");

        // Single request from requester 2.
        req = 4'b0100;
        @(negedge clk);
        chk("single_ack", 32'(ack), 32'h4);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_data", 32'(txd), 32'hA5);
        req = 4'b0000;
        @(negedge clk);
        chk("single_start", 32'(start), 32'd1);
        chk("single_ack_gone", 32'(ack), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("single_start_once", 32'(start), 32'd0);
        chk("single_grant_hold", 32'(grant), 32'h4);
        // Requester 3 pulses and withdraws while the byte is in flight.
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("single_grant_until_fall", 32'(grant), 32'h4);
        @(negedge clk);
        chk("single_grant_clear", 32'(grant), 32'h0);
        chk("single_active_clear", 32'(active), 32'd0);
        ack_or = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ack_or = ack_or | ack;
        end
        chk("withdrawn_no_ack", 32'(ack_or), 32'h0);

        // Start timeout: pointer is at 3, requester 0 wins via wrap.
        busy_en = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        chk("to_wrap_ack", 32'(ack), 32'h1);
        req = 4'b0010;
        @(negedge clk);
        chk("to_start", 32'(start), 32'd1);
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_err_delay", 32'(n), 32'd17);
        chk("to_grant_clear", 32'(grant), 32'h0);
        chk("to_idle", 32'(active), 32'd0);
        busy_en = 1'b1;
        @(negedge clk);
        chk("to_err_pulse", 32'(err), 32'd0);
        chk("to_next_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        wait_idle("to");

`ifdef UART_TX_LOCK_EN
        // Packet lock: requester 1 sends three bytes while requester 0 waits.
        data[15:8] = 8'h11;
        req = 4'b0010;
        @(negedge clk);
        chk("lock_b1_ack", 32'(ack), 32'h2);
        req = 4'b0011;
        data[15:8] = 8'h22;
        wait_ack("lock_b2");
        chk("lock_b2_ack", 32'(ack), 32'h2);
        chk("lock_b2_data", 32'(txd), 32'h22);
        data[15:8] = 8'h33;
        last = 4'b0010;
        wait_ack("lock_b3");
        chk("lock_b3_ack", 32'(ack), 32'h2);
        chk("lock_b3_data", 32'(txd), 32'h33);
        req = 4'b0001;
        last = 4'b0000;
        wait_ack("lock_rel");
        chk("lock_rel_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        wait_idle("lock");
`endif

        // Guard gap instance: two requests, 5 gap cycles between them.
        req_g = 4'b0011;
        @(negedge clk);
        chk("gap_ack0", 32'(ack_g), 32'h1);
        req_g = 4'b0010;
        n = 0;
        while (!busy_g && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy_g && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("gap_busy_fell", 32'(busy_g), 32'd0);
        n = 0;
        gapc = 0;
        while (ack_g == 4'b0000 && n < 30) begin
            @(negedge clk);
            n++;
            if (active_g && grant_g == 4'b0000 && ack_g == 4'b0000) gapc++;
        end
        chk("gap_ack_latency", 32'(n), 32'd7);
        chk("gap_idle_cycles", 32'(gapc), 32'd5);
        chk("gap_ack1", 32'(ack_g), 32'h2);
        chk("gap_data1", 32'(txd_g), 32'(bytes[1]));
        req_g = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
